// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode pipeline: word geometry, opcodes
// and the fetch state encoding.
package cpu_pkg;

  localparam int unsigned IW  = 18;
  localparam int unsigned AW  = 5;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] HALT_OP    = 4'b1000;
  localparam logic [OPW-1:0] OP_MOV_IMM = 4'b1100;
  localparam logic [OPW-1:0] OP_OR      = 4'b1101;
  localparam logic [OPW-1:0] OP_XOR     = 4'b1111;
  localparam logic [OPW-1:0] OP_AND     = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/prog_ram.sv
// Program store: one synchronous write port and one registered read port.
// Only the read register is reset; the array contents survive reset.
module prog_ram #(
  parameter int unsigned AW = 5,
  parameter int unsigned IW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [IW-1:0] mem_r [DEPTH];
  logic [IW-1:0] rdata_r;

  // array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read; holds its word whenever re is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program store, PC and a four-state fetch FSM
// that hands one instruction per two cycles to the decoder.
module instr_fetch_unit #(
  parameter int unsigned     IW      = cpu_pkg::IW,
  parameter int unsigned     AW      = cpu_pkg::AW,
  parameter int unsigned     OPW     = cpu_pkg::OPW,
  parameter logic [OPW-1:0]  HALT_OP = cpu_pkg::HALT_OP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          run,
  input  logic          stall,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  output logic [IW-1:0] id,
  output logic          id_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);

  import cpu_pkg::*;

  fetch_state_e  state_r;
  fetch_state_e  state_nxt_s;
  logic [AW-1:0] pc_r;
  logic [AW-1:0] pc_nxt_s;
  logic          id_valid_r;
  logic          id_valid_nxt_s;
  logic          halted_r;
  logic          halted_nxt_s;
  logic          mem_re_s;
  logic          mem_we_s;
  logic [IW-1:0] id_word_s;
  logic          is_halt_s;

  // The read register of the store doubles as the id register, so id only
  // changes on the FETCH->ISSUE edge and keeps the HALT word afterwards.
  prog_ram #(
    .AW (AW),
    .IW (IW)
  ) u_prog_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_s),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (mem_re_s),
    .raddr (pc_r),
    .rdata (id_word_s)
  );

  assign is_halt_s = (id_word_s[IW-1 -: OPW] == HALT_OP);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; HALT takes priority over any jump request
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (stall) begin
          state_nxt_s = ST_ISSUE;
        end else if (is_halt_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (run) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // next values of the registered outputs and store control strobes
  always_comb begin
    pc_nxt_s       = pc_r;
    id_valid_nxt_s = id_valid_r;
    halted_nxt_s   = halted_r;
    mem_re_s       = 1'b0;
    mem_we_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mem_we_s       = prog_we;
        id_valid_nxt_s = 1'b0;
        if (run) begin
          pc_nxt_s     = {AW{1'b0}};
          halted_nxt_s = 1'b0;
        end else begin
          pc_nxt_s     = pc_r;
          halted_nxt_s = halted_r;
        end
      end
      ST_FETCH: begin
        mem_re_s       = 1'b1;
        id_valid_nxt_s = 1'b1;
        halted_nxt_s   = 1'b0;
      end
      ST_ISSUE: begin
        if (stall) begin
          id_valid_nxt_s = 1'b1;
        end else if (is_halt_s) begin
          id_valid_nxt_s = 1'b0;
          halted_nxt_s   = 1'b1;
        end else if (jmp_en) begin
          id_valid_nxt_s = 1'b0;
          pc_nxt_s       = jmp_addr;
        end else begin
          id_valid_nxt_s = 1'b0;
          pc_nxt_s       = pc_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_HALT: begin
        mem_we_s       = prog_we;
        id_valid_nxt_s = 1'b0;
        if (run) begin
          pc_nxt_s     = {AW{1'b0}};
          halted_nxt_s = 1'b0;
        end else begin
          pc_nxt_s     = pc_r;
          halted_nxt_s = 1'b1;
        end
      end
      default: begin
        pc_nxt_s       = {AW{1'b0}};
        id_valid_nxt_s = 1'b0;
        halted_nxt_s   = 1'b0;
      end
    endcase
  end

  // registered pc / valid / halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= {AW{1'b0}};
      id_valid_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      pc_r       <= pc_nxt_s;
      id_valid_r <= id_valid_nxt_s;
      halted_r   <= halted_nxt_s;
    end
  end

  assign id       = id_word_s;
  assign id_valid = id_valid_r;
  assign pc       = pc_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [17:0] prog_data;
  logic        run;
  logic        stall;
  logic        jmp_en;
  logic [4:0]  jmp_addr;
  logic [17:0] id;
  logic        id_valid;
  logic [4:0]  pc;
  logic        halted;

  int n_cmp;
  int n_err;
  logic [17:0] model [32];
  logic [17:0] prog7 [7];

  instr_fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .run       (run),
    .stall     (stall),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .id        (id),
    .id_valid  (id_valid),
    .pc        (pc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [17:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
    model[a] = d;
  endtask

  // Pulse run and follow the expected issue stream until HALT or max_iss issues.
  task automatic walk(input int max_iss, input int stall_pc, input int stall_n,
                      input int jmp_pc, input logic [4:0] jmp_tgt, input bit wr_blocked);
    logic [4:0]  epc;
    logic [17:0] eid;
    epc = 5'd0;
    run = 1'b1;
    step();
    run = 1'b0;
    if (wr_blocked) begin
      prog_we = 1'b1; prog_addr = 5'd4; prog_data = 18'd0;
    end
    chk("fetch0_valid", {31'd0, id_valid}, 32'd0);
    for (int k = 0; k < max_iss; k++) begin
      step();
      eid = model[epc];
      chk("issue_valid", {31'd0, id_valid}, 32'd1);
      chk("issue_pc", {27'd0, pc}, {27'd0, epc});
      chk("issue_id", {14'd0, id}, {14'd0, eid});
      if (int'(epc) == stall_pc) begin
        stall = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          step();
          chk("stall_valid", {31'd0, id_valid}, 32'd1);
          chk("stall_pc", {27'd0, pc}, {27'd0, epc});
          chk("stall_id", {14'd0, id}, {14'd0, eid});
        end
        stall = 1'b0;
      end
      if (k == max_iss - 1 && eid[17:14] != 4'b1000) begin
        prog_we = 1'b0;
        return;
      end
      if (int'(epc) == jmp_pc) begin
        jmp_en = 1'b1; jmp_addr = jmp_tgt;
      end
      step();
      jmp_en = 1'b0;
      if (eid[17:14] == 4'b1000) begin
        prog_we = 1'b0;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, id_valid}, 32'd0);
        chk("halt_id", {14'd0, id}, {14'd0, eid});
        chk("halt_pc", {27'd0, pc}, {27'd0, epc});
        return;
      end
      chk("fetch_valid", {31'd0, id_valid}, 32'd0);
      chk("fetch_halted", {31'd0, halted}, 32'd0);
      epc = (int'(epc) == jmp_pc) ? jmp_tgt : epc + 5'd1;
    end
    prog_we = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    prog7[0] = 18'b110010100011001001;
    prog7[1] = 18'b000111010111101100;
    prog7[2] = 18'b110010000010010011;
    prog7[3] = 18'b110110100010101101;
    prog7[4] = 18'b111110100010001011;
    prog7[5] = 18'b111010100001101001;
    prog7[6] = 18'b100010111011001100;
    for (int i = 0; i < 32; i++) model[i] = 18'bx;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = 5'd0; prog_data = 18'd0;
    run = 1'b0; stall = 1'b0; jmp_en = 1'b0; jmp_addr = 5'd0;
    #12;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_id", {14'd0, id}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    step(); step();
    chk("idle_valid", {31'd0, id_valid}, 32'd0);

    for (int i = 0; i < 7; i++) load(5'(i), prog7[i]);
    walk(40, -1, 0, -1, 5'd0, 1'b0);
    chk("s1_halted", {31'd0, halted}, 32'd1);
    chk("s1_id", {14'd0, id}, {14'd0, 18'b100010111011001100});

    walk(40, 2, 3, -1, 5'd0, 1'b0);
    chk("s2_pc", {27'd0, pc}, 32'd6);

    walk(40, -1, 0, 1, 5'd5, 1'b0);
    chk("s3_pc", {27'd0, pc}, 32'd6);

    walk(40, -1, 0, 6, 5'd0, 1'b0);
    chk("halt_beats_jmp", {31'd0, halted}, 32'd1);

    walk(40, -1, 0, -1, 5'd0, 1'b1);
    chk("blocked_write_halted", {31'd0, halted}, 32'd1);
    load(5'd4, 18'd0);
    walk(40, -1, 0, -1, 5'd0, 1'b0);
    chk("halt_write_halted", {31'd0, halted}, 32'd1);
    load(5'd4, prog7[4]);

    walk(4, -1, 0, -1, 5'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, id_valid}, 32'd0);
    chk("midrst_pc", {27'd0, pc}, 32'd0);
    chk("midrst_id", {14'd0, id}, 32'd0);
    #2 rst_n = 1'b1;
    walk(40, -1, 0, -1, 5'd0, 1'b0);
    chk("rerun_halted", {31'd0, halted}, 32'd1);

    for (int i = 0; i < 32; i++) load(5'(i), {4'b0001, 9'd0, 5'(31 - i)});
    walk(33, -1, 0, -1, 5'd0, 1'b0);
    chk("wrap_pc", {27'd0, pc}, 32'd0);
    chk("wrap_halted", {31'd0, halted}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
